// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared FSM encoding and default reset vector for the fetch-stage PC unit
package pc_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;
  localparam logic [7:0] DEFAULT_RESET_VECTOR = 8'hC8;
endpackage

// File: rtl/pc_ctrl_ras_stack.sv
// ras_stack: circular return-address LIFO; a push while full overwrites the oldest entry
module ras_stack #(
  parameter int WIDTH     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  // ptr_q is the next write slot; when full it also points at the oldest entry
  assign top_o   = mem_q[ptr_q - 1'b1];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(RAS_DEPTH);
  assign ovf_o   = push_i && full_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + 1'b1;
      cnt_q <= full_o ? cnt_q : cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (push_i) mem_q[ptr_q] <= data_i;
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter with halt/resume FSM, stall, jump, relative branch and call/return
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_off_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] call_target_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             halted_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             err_ovf_o,
  output logic             err_unf_o
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, top;
  logic             ovf_q, ovf_d, unf_q, unf_d, push, pop, ovf;
  assign pc_inc = pc_q + 1'b1;
  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (top),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o),
    .ovf_o   (ovf)
  );
  // losing requests are dropped outright, so only the winner may touch the RAS
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (state_q == ST_HALTED) begin
      if (resume_i && !halt_req_i) state_d = ST_RUN;
    end else if (halt_req_i) begin
      state_d = ST_HALTED;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (ret_i) begin
      pop   = !ras_empty_o;
      pc_d  = ras_empty_o ? pc_inc : top;
      unf_d = unf_q || ras_empty_o;
    end else if (call_i) begin
      push  = 1'b1;
      pc_d  = call_target_i;
      ovf_d = ovf_q || ovf;
    end else begin
      pc_d = jump_i ? jump_target_i : branch_i ? pc_q + branch_off_i : pc_inc;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign pc_o      = pc_q;
  assign halted_o  = state_q == ST_HALTED;
  assign err_ovf_o = ovf_q;
  assign err_unf_o = unf_q;
endmodule
